// File: rtl/icache_tag_arbiter.sv
// Tag SRAM front-end: arbitrates lookup reads against fill writes on the shared
// single-port banks and walks every set/way to invalidate the array on flush.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_NORMAL | lookup/fill arbitration; fill wins ties unless lookup_prio_q
// ST_FLUSH  | one invalidating write per cycle, set-major, way-minor
module icache_tag_arbiter #(
   parameter int              INDEX_W        = 6,
   parameter int              WAY_W          = 3,
   parameter int              TAG_W          = 44,
   parameter bit              FLUSH_ON_RESET = 1'b1,
   parameter logic [TAG_W-1:0] INV_WDATA     = '0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               lookup_req_valid,
   input  logic [INDEX_W-1:0] lookup_req_index,
   output logic               lookup_req_ready,
   input  logic               fill_req_valid,
   input  logic [INDEX_W-1:0] fill_req_index,
   input  logic [WAY_W-1:0]   fill_req_way,
   input  logic [TAG_W-1:0]   fill_req_wdata,
   output logic               fill_req_ready,
   input  logic               flush_req,
   output logic               flush_busy,
   output logic               flush_done,
   output logic               lookup2tag_array_valid,
   output logic [INDEX_W-1:0] lookup2tag_array_index,
   output logic               fill2tag_array_valid,
   output logic [INDEX_W-1:0] fill2tag_array_index,
   output logic [WAY_W-1:0]   fill2tag_array_way,
   output logic [TAG_W-1:0]   fill2tag_array_wdata
);

   localparam int CNT_W = INDEX_W + WAY_W;

   typedef enum logic {ST_NORMAL, ST_FLUSH} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               lookup_prio_q, lookup_prio_d;
   logic               flush_done_q, flush_done_d;
   logic               normal_act, flush_act;
   logic               grant_fill, grant_lookup;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= FLUSH_ON_RESET ? ST_FLUSH : ST_NORMAL;
         cnt_q         <= '0;
         lookup_prio_q <= 1'b0;
         flush_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         lookup_prio_q <= lookup_prio_d;
         flush_done_q  <= flush_done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      lookup_prio_d = lookup_prio_q;
      flush_done_d  = 1'b0;
      case (state_q)
         ST_NORMAL: begin
            if (grant_lookup)
               lookup_prio_d = 1'b0;
            else if (grant_fill && lookup_req_valid)
               lookup_prio_d = 1'b1;
            // Same-cycle grant above still completes; the walk starts next cycle.
            if (flush_req) begin
               state_d       = ST_FLUSH;
               cnt_d         = '0;
               lookup_prio_d = 1'b0;
            end
         end
         ST_FLUSH: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (&cnt_q) begin
               state_d      = ST_NORMAL;
               flush_done_d = 1'b1;
            end
         end
         default: state_d = ST_NORMAL;
      endcase
   end

   always_comb begin
      normal_act   = (state_q == ST_NORMAL) && !reset;
      flush_act    = (state_q == ST_FLUSH) && !reset;
      grant_fill   = normal_act && fill_req_valid && !(lookup_req_valid && lookup_prio_q);
      grant_lookup = normal_act && lookup_req_valid && !grant_fill;

      lookup_req_ready       = grant_lookup;
      fill_req_ready         = grant_fill;
      lookup2tag_array_valid = grant_lookup;
      lookup2tag_array_index = lookup_req_index;

      fill2tag_array_valid = grant_fill || flush_act;
      fill2tag_array_index = fill_req_index;
      fill2tag_array_way   = fill_req_way;
      fill2tag_array_wdata = fill_req_wdata;
      if (flush_act) begin
         fill2tag_array_index = cnt_q[CNT_W-1:WAY_W];
         fill2tag_array_way   = cnt_q[WAY_W-1:0];
         fill2tag_array_wdata = INV_WDATA;
      end

      flush_busy = (state_q == ST_FLUSH);
      flush_done = flush_done_q;
   end

endmodule
